// File: rtl/musical_score_pkg.sv
// Shared definitions for the score record/load path: note codes, tempo header
// geometry and the recorder state encoding.
package musical_score_pkg;

    typedef logic [3:0] note_t;

    localparam note_t NOTE_REST      = 4'h0;
    localparam note_t NOTE_END       = 4'hF;
    localparam int    TEMPO_WIDTH    = 26;
    localparam int    HEADER_NIBBLES = 7;
    localparam int    HEADER_BITS    = HEADER_NIBBLES * 4;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        RECORD,
        FINISH,
        DONE
    } record_state_t;

    // Header nibble k of the MSB-first tempo field (k = 0 is the most significant).
    function automatic note_t header_nibble(input logic [TEMPO_WIDTH-1:0] t,
                                            input logic [2:0] k);
        logic [HEADER_BITS-1:0] padded;
        note_t                  nib;
        padded = {{(HEADER_BITS-TEMPO_WIDTH){1'b0}}, t};
        nib    = NOTE_REST;
        for (int i = 0; i < HEADER_NIBBLES; i++) begin
            if (k == 3'(i)) begin
                nib = padded[(HEADER_NIBBLES-1-i)*4 +: 4];
            end
        end
        return nib;
    endfunction

endpackage

// File: rtl/musical_score_record_tick_gen.sv
// Loadable period counter: counts 0..period-1 while enabled and pulses tick on
// the last count of each period.
import musical_score_pkg::*;

module record_tick_gen (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TEMPO_WIDTH-1:0] period,
    input  logic                   enable,
    output logic                   tick
);

    logic [TEMPO_WIDTH-1:0] cnt_q;
    logic [TEMPO_WIDTH-1:0] cnt_d;

    assign tick = enable && (cnt_q == (period - TEMPO_WIDTH'(1)));

    // Next count: restart on load, wrap on tick, advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + TEMPO_WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/musical_score_record.sv
// Song recorder: writes a tempo header then one sampled note nibble per eighth
// note into the song RAM write port.
// Optional feature macro: MUSICAL_SCORE_RECORD_END_MARKER_EN (write 4'hF end marker,
// coerce detected 4'hF to rest).
import musical_score_pkg::*;

module musical_score_record #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   record_start,
    input  logic                   record_stop,
    input  logic [TEMPO_WIDTH-1:0] tempo,
    input  logic [3:0]             detected_note,
    input  logic                   note_valid,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [3:0]             mem_wdata,
    output logic                   recording,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  note_count,
    output logic                   eighth_tick
);

    localparam logic [ADDR_WIDTH-1:0] LAST_NOTE_ADDR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0] FIRST_NOTE_ADDR = ADDR_WIDTH'(HEADER_NIBBLES);

    record_state_t          state_q, state_d;
    logic [2:0]             hdr_idx_q, hdr_idx_d;
    logic [TEMPO_WIDTH-1:0] tempo_q, tempo_d;
    note_t                  capture_q, capture_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    note_t                  mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH-1:0]  note_count_q, note_count_d;

    logic [TEMPO_WIDTH-1:0] tempo_clamped;
    logic [ADDR_WIDTH-1:0]  note_addr;
    note_t                  note_in;
    logic                   tick;

    assign tempo_clamped = (tempo < TEMPO_WIDTH'(2)) ? TEMPO_WIDTH'(2) : tempo;
    assign note_addr     = FIRST_NOTE_ADDR + note_count_q;

`ifdef MUSICAL_SCORE_RECORD_END_MARKER_EN
    assign note_in = (detected_note == NOTE_END) ? NOTE_REST : detected_note;
`else
    assign note_in = detected_note;
`endif

    // The counter is held at zero until RECORD so the first eighth starts on entry.
    record_tick_gen u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (state_q != RECORD),
        .period (tempo_q),
        .enable (state_q == RECORD),
        .tick   (tick)
    );

    // Next-state, capture and write-port logic.
    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        tempo_d      = tempo_q;
        capture_d    = capture_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        note_count_d = note_count_q;
        case (state_q)
            IDLE, DONE: begin
                if (record_start) begin
                    // Header nibble 0 goes out right away, the rest follow from HEADER.
                    state_d      = HEADER;
                    tempo_d      = tempo_clamped;
                    hdr_idx_d    = 3'd1;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = '0;
                    mem_wdata_d  = header_nibble(tempo_clamped, 3'd0);
                    note_count_d = '0;
                    capture_d    = NOTE_REST;
                end
            end
            HEADER: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = {{(ADDR_WIDTH-3){1'b0}}, hdr_idx_q};
                mem_wdata_d = header_nibble(tempo_q, hdr_idx_q);
                hdr_idx_d   = hdr_idx_q + 3'd1;
                capture_d   = NOTE_REST;
                if (hdr_idx_q == 3'(HEADER_NIBBLES-1)) begin
                    state_d = RECORD;
                end
            end
            RECORD: begin
                if (tick) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = note_addr;
                    mem_wdata_d  = note_valid ? note_in : capture_q;
                    note_count_d = note_count_q + ADDR_WIDTH'(1);
                    capture_d    = NOTE_REST;
                    if (record_stop || (note_addr == LAST_NOTE_ADDR)) begin
                        state_d = FINISH;
                    end
                end else begin
                    if (note_valid) begin
                        capture_d = note_in;
                    end
                    if (record_stop) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = DONE;
`ifdef MUSICAL_SCORE_RECORD_END_MARKER_EN
                mem_we_d    = 1'b1;
                mem_addr_d  = note_addr;
                mem_wdata_d = NOTE_END;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any recording immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hdr_idx_q    <= '0;
            tempo_q      <= '0;
            capture_q    <= NOTE_REST;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= NOTE_REST;
            note_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            tempo_q      <= tempo_d;
            capture_q    <= capture_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            note_count_q <= note_count_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign note_count  = note_count_q;
    assign eighth_tick = tick;
    assign recording   = (state_q == HEADER) || (state_q == RECORD) || (state_q == FINISH);
    assign done        = (state_q == DONE);

endmodule
